// File: rtl/store_align_unit.sv
// Store alignment unit: turns byte/half/word stores at any byte address into
// word-aligned write beats with lane strobes, splitting boundary-crossing stores.
module store_align_unit #(
   parameter int ALLOW_SPLIT = 1
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_data,
   input  logic [1:0]  req_size,
   output logic        mem_valid,
   input  logic        mem_ready,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wstrb,
   output logic        done,
   output logic        err
);

   typedef enum logic [1:0] {IDLE, BEAT0, BEAT1} state_t;

   state_t      state_q;
   logic [29:0] word_q;
   logic [31:0] data_q;
   logic [3:0]  mask_q;
   logic [1:0]  off_q;
   logic        cross_q;
   logic        done_q;
   logic        err_q;

   logic [3:0]  req_mask;
   logic [2:0]  req_nbytes;
   logic [2:0]  req_end;
   logic        req_cross;
   logic        req_reject;

   always_comb begin
      req_mask   = 4'b0000;
      req_nbytes = 3'd0;
      case (req_size)
         2'b00:   begin req_mask = 4'b0001; req_nbytes = 3'd1; end
         2'b01:   begin req_mask = 4'b0011; req_nbytes = 3'd2; end
         2'b10:   begin req_mask = 4'b1111; req_nbytes = 3'd4; end
         default: begin req_mask = 4'b0000; req_nbytes = 3'd0; end
      endcase
      req_end    = {1'b0, req_addr[1:0]} + req_nbytes;
      req_cross  = (req_end > 3'd4);
      req_reject = (req_size == 2'b11) || (req_cross && (ALLOW_SPLIT == 0));
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         word_q  <= '0;
         data_q  <= '0;
         mask_q  <= '0;
         off_q   <= '0;
         cross_q <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
         case (state_q)
            IDLE: begin
               if (req_valid) begin
                  if (req_reject) begin
                     err_q <= 1'b1;
                  end else begin
                     word_q  <= req_addr[31:2];
                     data_q  <= req_data;
                     mask_q  <= req_mask;
                     off_q   <= req_addr[1:0];
                     cross_q <= req_cross;
                     state_q <= BEAT0;
                  end
               end
            end
            BEAT0: begin
               if (mem_ready) begin
                  if (cross_q) begin
                     state_q <= BEAT1;
                  end else begin
                     state_q <= IDLE;
                     done_q  <= 1'b1;
                  end
               end
            end
            BEAT1: begin
               if (mem_ready) begin
                  state_q <= IDLE;
                  done_q  <= 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Beat outputs depend only on registered state, so they stay stable under backpressure.
   logic [31:0] base_addr;
   logic [2:0]  hi_bytes;
   logic [4:0]  lo_shift;
   logic [5:0]  hi_shift;

   always_comb begin
      base_addr = {word_q, 2'b00};
      hi_bytes  = 3'd4 - {1'b0, off_q};
      lo_shift  = {off_q, 3'b000};
      hi_shift  = {hi_bytes, 3'b000};
      mem_valid = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      mem_wstrb = 4'b0000;
      case (state_q)
         BEAT0: begin
            mem_valid = 1'b1;
            mem_addr  = base_addr;
            mem_wdata = data_q << lo_shift;
            mem_wstrb = mask_q << off_q;
         end
         BEAT1: begin
            mem_valid = 1'b1;
            mem_addr  = base_addr + 32'd4;
            mem_wdata = data_q >> hi_shift;
            mem_wstrb = mask_q >> hi_bytes;
         end
         default: ;
      endcase
   end

   assign req_ready = reset_n && (state_q == IDLE);
   assign done      = done_q;
   assign err       = err_q;

endmodule

// File: tb/tb_store_align_unit.sv
// Directed bench for store_align_unit with a beat scoreboard; a second instance
// is built with splitting disabled to exercise the reject path.
module tb_store_align_unit;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
   } beat_t;

   logic        clk;
   logic        reset_n;
   logic        req_valid, req_ready;
   logic [31:0] req_addr, req_data;
   logic [1:0]  req_size;
   logic        mem_valid, mem_ready;
   logic [31:0] mem_addr, mem_wdata;
   logic [3:0]  mem_wstrb;
   logic        done, err;

   logic        req_valid1, req_ready1;
   logic [31:0] req_addr1, req_data1;
   logic [1:0]  req_size1;
   logic        mem_valid1, mem_ready1;
   logic [31:0] mem_addr1, mem_wdata1;
   logic [3:0]  mem_wstrb1;
   logic        done1, err1;

   beat_t sb[$];
   int    errors = 0;
   int    checks = 0;

   store_align_unit #(.ALLOW_SPLIT(1)) u0 (
      .clk(clk), .reset_n(reset_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_addr(req_addr), .req_data(req_data), .req_size(req_size),
      .mem_valid(mem_valid), .mem_ready(mem_ready),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
      .done(done), .err(err)
   );

   store_align_unit #(.ALLOW_SPLIT(0)) u1 (
      .clk(clk), .reset_n(reset_n),
      .req_valid(req_valid1), .req_ready(req_ready1),
      .req_addr(req_addr1), .req_data(req_data1), .req_size(req_size1),
      .mem_valid(mem_valid1), .mem_ready(mem_ready1),
      .mem_addr(mem_addr1), .mem_wdata(mem_wdata1), .mem_wstrb(mem_wstrb1),
      .done(done1), .err(err1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp_v);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      beat_t b;
      b.addr  = a;
      b.wdata = d;
      b.wstrb = s;
      sb.push_back(b);
   endtask

   task automatic issue(input string tag, input logic [31:0] a, input logic [31:0] d,
                        input logic [1:0] sz);
      chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
      req_valid = 1'b1;
      req_addr  = a;
      req_data  = d;
      req_size  = sz;
      tick();
      req_valid = 1'b0;
      req_addr  = '0;
      req_data  = '0;
      req_size  = '0;
   endtask

   // Compares the current beat with the scoreboard head; pops only on handshake.
   task automatic check_beat(input string tag);
      beat_t e;
      chk({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
      chk({tag, "_mem_valid"}, 32'(mem_valid), 32'd1);
      chk({tag, "_done_low"}, 32'(done), 32'd0);
      if (sb.size() != 0) begin
         e = sb[0];
         chk({tag, "_addr"}, mem_addr, e.addr);
         chk({tag, "_wdata"}, mem_wdata, e.wdata);
         chk({tag, "_wstrb"}, 32'(mem_wstrb), 32'(e.wstrb));
         if (mem_ready) begin
            void'(sb.pop_front());
            $display("beat %s addr=%h wdata=%h wstrb=%b", tag, mem_addr, mem_wdata, mem_wstrb);
         end
      end
   endtask

   task automatic run_beats(input string tag, input int n);
      for (int i = 0; i < n; i++) begin
         check_beat($sformatf("%s_b%0d", tag, i));
         tick();
      end
      chk({tag, "_done"}, 32'(done), 32'd1);
      chk({tag, "_idle_valid"}, 32'(mem_valid), 32'd0);
      chk({tag, "_idle_addr"}, mem_addr, 32'd0);
      chk({tag, "_idle_ready"}, 32'(req_ready), 32'd1);
      $display("store %s done", tag);
   endtask

   initial begin
      reset_n    = 1'b0;
      req_valid  = 1'b0; req_addr  = '0; req_data  = '0; req_size  = '0;
      mem_ready  = 1'b1;
      req_valid1 = 1'b0; req_addr1 = '0; req_data1 = '0; req_size1 = '0;
      mem_ready1 = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_mem_valid", 32'(mem_valid), 32'd0);
      chk("rst_mem_addr", mem_addr, 32'd0);
      chk("rst_mem_wdata", mem_wdata, 32'd0);
      chk("rst_mem_wstrb", 32'(mem_wstrb), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      reset_n = 1'b1;
      #1;

      // Word store, aligned.
      push(32'h100, 32'hDEADBEEF, 4'b1111);
      issue("word", 32'h100, 32'hDEADBEEF, 2'b10);
      run_beats("word", 1);

      // Byte store accepted in the same cycle as the previous done pulse.
      push(32'h200, 32'hAB000000, 4'b1000);
      issue("byte", 32'h203, 32'h000000AB, 2'b00);
      run_beats("byte", 1);
      tick();
      chk("byte_done_clear", 32'(done), 32'd0);

      // Split half-word across a word boundary.
      push(32'h304, 32'hFE000000, 4'b1000);
      push(32'h308, 32'h000000CA, 4'b0001);
      issue("split", 32'h307, 32'h0000CAFE, 2'b01);
      run_beats("split", 2);
      tick();
      chk("split_single_done", 32'(done), 32'd0);

      // Backpressure: three stalled cycles then the handshake.
      mem_ready = 1'b0;
      push(32'h100, 32'hDEADBEEF, 4'b1111);
      issue("bp", 32'h100, 32'hDEADBEEF, 2'b10);
      for (int i = 0; i < 4; i++) begin
         if (i == 3) mem_ready = 1'b1;
         chk($sformatf("bp_req_ready_%0d", i), 32'(req_ready), 32'd0);
         check_beat($sformatf("bp_c%0d", i));
         tick();
      end
      chk("bp_done", 32'(done), 32'd1);
      tick();

      // Illegal size.
      issue("illegal", 32'h100, 32'h12345678, 2'b11);
      chk("illegal_err", 32'(err), 32'd1);
      chk("illegal_no_valid", 32'(mem_valid), 32'd0);
      chk("illegal_no_done", 32'(done), 32'd0);
      chk("illegal_ready", 32'(req_ready), 32'd1);
      tick();
      chk("illegal_err_clear", 32'(err), 32'd0);
      chk("illegal_still_idle", 32'(mem_valid), 32'd0);
      $display("store illegal rejected");

      // Crossing word rejected when splitting is disabled.
      chk("nosplit_ready", 32'(req_ready1), 32'd1);
      req_valid1 = 1'b1; req_addr1 = 32'h102; req_data1 = 32'h55667788; req_size1 = 2'b10;
      tick();
      req_valid1 = 1'b0;
      chk("nosplit_err", 32'(err1), 32'd1);
      chk("nosplit_no_valid", 32'(mem_valid1), 32'd0);
      chk("nosplit_no_done", 32'(done1), 32'd0);
      tick();
      chk("nosplit_err_clear", 32'(err1), 32'd0);
      $display("store nosplit rejected");

      // Address wrap on the second beat.
      push(32'hFFFFFFFC, 32'h33440000, 4'b1100);
      push(32'h00000000, 32'h00001122, 4'b0011);
      issue("wrap", 32'hFFFFFFFE, 32'h11223344, 2'b10);
      run_beats("wrap", 2);
      tick();

      // Reset while BEAT1 is stalled.
      push(32'h304, 32'hFE000000, 4'b1000);
      push(32'h308, 32'h000000CA, 4'b0001);
      issue("rstmid", 32'h307, 32'h0000CAFE, 2'b01);
      check_beat("rstmid_b0");
      tick();
      mem_ready = 1'b0;
      check_beat("rstmid_b1");
      tick();
      check_beat("rstmid_b1_hold");
      #2;
      reset_n = 1'b0;
      #1;
      chk("rstmid_valid_drop", 32'(mem_valid), 32'd0);
      chk("rstmid_addr_zero", mem_addr, 32'd0);
      chk("rstmid_wstrb_zero", 32'(mem_wstrb), 32'd0);
      chk("rstmid_ready_low", 32'(req_ready), 32'd0);
      chk("rstmid_no_done", 32'(done), 32'd0);
      chk("rstmid_no_err", 32'(err), 32'd0);
      sb.delete();
      mem_ready = 1'b1;
      tick();
      chk("rstmid_held_done", 32'(done), 32'd0);
      reset_n = 1'b1;
      #1;
      chk("rstmid_ready_after", 32'(req_ready), 32'd1);
      $display("store rstmid abandoned");

      // First accept right after release.
      push(32'h400, 32'h00005A00, 4'b0010);
      issue("postrst", 32'h401, 32'h0000005A, 2'b00);
      run_beats("postrst", 1);
      tick();

      chk("sb_drained", 32'(sb.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
